load_store_unit: RTL and testbench

- Memory stage of the RV32I core; sits directly downstream of the ALU.
- Takes the ALU result as the effective address of OP_L/OP_S instructions and drives a req/gnt/rvalid data-memory port.
- Returns sign/zero-extended load data to writeback; flags misaligned, illegal and timed-out accesses.

---
 rtl/load_store_unit_pkg.sv | 45 ++++
 rtl/load_store_unit_align.sv | 45 ++++
 rtl/load_store_unit.sv | 151 +++++++++++++++
 tb/tb_load_store_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared RV32I constants for the memory stage: opcodes, func3 codes,
// LSU state encoding and response cause codes.
package load_store_unit_pkg;

  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;

  localparam logic [2:0] LB_func3  = 3'b000;
  localparam logic [2:0] LH_func3  = 3'b001;
  localparam logic [2:0] LW_func3  = 3'b010;
  localparam logic [2:0] LBU_func3 = 3'b100;
  localparam logic [2:0] LHU_func3 = 3'b101;
  localparam logic [2:0] SB_func3  = 3'b000;
  localparam logic [2:0] SH_func3  = 3'b001;
  localparam logic [2:0] SW_func3  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_MISALIGN = 2'd1,
    CAUSE_ILLEGAL  = 2'd2,
    CAUSE_BUSERR   = 2'd3
  } lsu_cause_e;

  // Illegal width takes priority over misalignment.
  function automatic lsu_cause_e check_access(input logic is_store,
                                              input logic [2:0] f3,
                                              input logic [1:0] lo);
    logic ill;
    logic mis;
    if (is_store) ill = f3[2] | (f3[1:0] == 2'b11);
    else          ill = (f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111);
    mis = ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00));
    if (ill)      return CAUSE_ILLEGAL;
    else if (mis) return CAUSE_MISALIGN;
    else          return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Byte-lane steering: store replication/strobes and load extraction/extension.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_data,
  input  logic [2:0]  ld_func3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_rdata,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  always_comb begin
    wdata = st_data;
    wstrb = 4'b1111;
    case (st_size)
      2'b00: begin
        wdata = {4{st_data[7:0]}};
        wstrb = 4'b0001 << st_addr_lo;
      end
      2'b01: begin
        wdata = {2{st_data[15:0]}};
        wstrb = 4'b0011 << st_addr_lo;
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted = ld_rdata >> {ld_addr_lo, 3'b000};
    case (ld_func3)
      LB_func3:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
      LH_func3:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
      LBU_func3: ld_data = {24'd0, shifted[7:0]};
      LHU_func3: ld_data = {16'd0, shifted[15:0]};
      default:   ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory stage: drives the req/gnt/rvalid data port and returns
// extended load data or an error response to writeback.
//
// state | meaning
// IDLE  | ready; accept OP_L/OP_S, pre-check width and alignment
// REQ   | dm_req held stable until dm_gnt
// WAIT  | load granted, waiting for dm_rvalid or timeout
// RESP  | one-cycle resp_valid pulse
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int WAIT_MAX = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [2:0]  func3,
  input  logic [31:0] alu_out,
  input  logic [31:0] store_data,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_misalign,
  output logic        resp_illegal,
  output logic        resp_buserr,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_wstrb,
  output logic [31:0] dm_wdata,
  input  logic        dm_gnt,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata
);

  localparam int CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  lsu_state_e    state;
  logic [CW-1:0] cnt;
  logic          is_store_q;
  logic [2:0]    func3_q;
  logic [1:0]    addr_lo_q;

  logic          acc_op;
  logic          is_store;
  lsu_cause_e    cause;
  logic [31:0]   fmt_wdata;
  logic [3:0]    fmt_wstrb;
  logic [31:0]   ld_data;

  assign acc_op   = (opcode == OP_L) || (opcode == OP_S);
  assign is_store = (opcode == OP_S);
  assign cause    = check_access(is_store, func3, alu_out[1:0]);
  assign in_ready = (state == IDLE);

  lsu_align u_align (
    .st_size    (func3[1:0]),
    .st_addr_lo (alu_out[1:0]),
    .st_data    (store_data),
    .ld_func3   (func3_q),
    .ld_addr_lo (addr_lo_q),
    .ld_rdata   (dm_rdata),
    .wdata      (fmt_wdata),
    .wstrb      (fmt_wstrb),
    .ld_data    (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      is_store_q    <= 1'b0;
      func3_q       <= '0;
      addr_lo_q     <= '0;
      resp_valid    <= 1'b0;
      resp_data     <= '0;
      resp_misalign <= 1'b0;
      resp_illegal  <= 1'b0;
      resp_buserr   <= 1'b0;
      dm_req        <= 1'b0;
      dm_we         <= 1'b0;
      dm_addr       <= '0;
      dm_wstrb      <= '0;
      dm_wdata      <= '0;
    end else begin
      // Response outputs are pulses; they only carry content in RESP.
      resp_valid    <= 1'b0;
      resp_data     <= '0;
      resp_misalign <= 1'b0;
      resp_illegal  <= 1'b0;
      resp_buserr   <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && acc_op) begin
            if (cause != CAUSE_NONE) begin
              state         <= RESP;
              resp_valid    <= 1'b1;
              resp_illegal  <= (cause == CAUSE_ILLEGAL);
              resp_misalign <= (cause == CAUSE_MISALIGN);
            end else begin
              state      <= REQ;
              is_store_q <= is_store;
              func3_q    <= func3;
              addr_lo_q  <= alu_out[1:0];
              dm_req     <= 1'b1;
              dm_we      <= is_store;
              dm_addr    <= {alu_out[31:2], 2'b00};
              dm_wdata   <= is_store ? fmt_wdata : '0;
              dm_wstrb   <= is_store ? fmt_wstrb : '0;
            end
          end
        end
        REQ: begin
          if (dm_gnt) begin
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_wstrb <= '0;
            if (is_store_q) begin
              state      <= RESP;
              resp_valid <= 1'b1;
            end else if (dm_rvalid) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_data  <= ld_data;
            end else begin
              state <= WAIT;
              cnt   <= '0;
            end
          end
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          // Data arriving on the last allowed cycle still wins over timeout.
          if (dm_rvalid) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_data  <= ld_data;
          end else if (cnt == CW'(WAIT_MAX - 1)) begin
            state       <= RESP;
            resp_valid  <= 1'b1;
            resp_buserr <= 1'b1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed vector bench for load_store_unit with a scripted memory responder.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  opcode = '0;
  logic [2:0]  func3 = '0;
  logic [31:0] alu_out = '0;
  logic [31:0] store_data = '0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_misalign, resp_illegal, resp_buserr;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_wstrb;
  logic        dm_gnt = 1'b0;
  logic        dm_rvalid = 1'b0;
  logic [31:0] dm_rdata = '0;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  load_store_unit #(.WAIT_MAX(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .func3(func3), .alu_out(alu_out), .store_data(store_data),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_misalign(resp_misalign),
    .resp_illegal(resp_illegal), .resp_buserr(resp_buserr),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wstrb(dm_wstrb),
    .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata)
  );

  // flags = {illegal, misalign, buserr}; lat = cycles from accept to resp_valid, 0 = none
  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] rd;
    int          gd;
    int          rvd;
    int          lat;
    bit          req;
    logic [31:0] e_addr;
    logic [3:0]  e_wstrb;
    logic [31:0] e_wdata;
    logic [31:0] e_data;
    logic [2:0]  e_flags;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int rk, req_cnt, wait_cnt;
    bit saw_req, stable, ir_high, granted;
    logic [31:0] a_addr, a_wdata, r_data;
    logic [3:0] a_wstrb;
    logic a_we;
    logic [2:0] r_flags;
    v = vecs[i];
    rk = 0; req_cnt = 0; wait_cnt = 0;
    saw_req = 0; stable = 1; ir_high = 0; granted = 0;
    a_addr = '0; a_wdata = '0; a_wstrb = '0; a_we = 0; r_data = '0; r_flags = '0;
    @(negedge clk);
    in_valid = 1; opcode = v.op; func3 = v.f3; alu_out = v.addr; store_data = v.sd;
    @(posedge clk); #1;
    in_valid = 0; opcode = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      dm_gnt = 0; dm_rvalid = 0;
      if (in_ready) ir_high = 1;
      if (resp_valid) begin
        rk = k; r_data = resp_data;
        r_flags = {resp_illegal, resp_misalign, resp_buserr};
        break;
      end
      if (dm_req) begin
        if (!saw_req) begin
          a_addr = dm_addr; a_wdata = dm_wdata; a_wstrb = dm_wstrb; a_we = dm_we;
        end else if (dm_addr !== a_addr || dm_wdata !== a_wdata ||
                     dm_wstrb !== a_wstrb || dm_we !== a_we) begin
          stable = 0;
        end
        saw_req = 1;
        if (req_cnt == v.gd) begin
          dm_gnt = 1; granted = 1;
          if (v.op == OP_L && v.rvd == 0) begin dm_rvalid = 1; dm_rdata = v.rd; end
        end
        req_cnt++;
      end else if (granted) begin
        if (saw_req && req_cnt <= v.gd) stable = 0;
        wait_cnt++;
        if (wait_cnt == v.rvd) begin dm_rvalid = 1; dm_rdata = v.rd; end
      end
    end
    chk($sformatf("v%0d latency", i), rk, v.lat);
    chk($sformatf("v%0d req_seen", i), {31'd0, saw_req}, {31'd0, v.req});
    chk($sformatf("v%0d in_ready_high_while_busy", i), {31'd0, ir_high}, {31'd0, v.lat == 0});
    if (v.req) begin
      chk($sformatf("v%0d dm_addr", i), a_addr, v.e_addr);
      chk($sformatf("v%0d dm_wstrb", i), {28'd0, a_wstrb}, {28'd0, v.e_wstrb});
      chk($sformatf("v%0d dm_wdata", i), a_wdata, v.e_wdata);
      chk($sformatf("v%0d dm_we", i), {31'd0, a_we}, {31'd0, v.op == OP_S});
      chk($sformatf("v%0d req_stable", i), {31'd0, stable}, 32'd1);
    end
    if (v.lat != 0) begin
      chk($sformatf("v%0d resp_data", i), r_data, v.e_data);
      chk($sformatf("v%0d resp_flags", i), {29'd0, r_flags}, {29'd0, v.e_flags});
    end
    @(negedge clk);
    dm_gnt = 0; dm_rvalid = 0;
    chk($sformatf("v%0d in_ready_after", i), {31'd0, in_ready}, 32'd1);
    chk($sformatf("v%0d resp_idle", i),
        {28'd0, resp_valid, resp_illegal, resp_misalign, resp_buserr}, 32'd0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " dm_ctrl"}, {29'd0, dm_req, dm_we, in_ready}, 32'd1);
    chk({tag, " dm_wstrb"}, {28'd0, dm_wstrb}, 32'd0);
    chk({tag, " dm_addr"}, dm_addr, 32'd0);
    chk({tag, " dm_wdata"}, dm_wdata, 32'd0);
    chk({tag, " resp_data"}, resp_data, 32'd0);
    chk({tag, " resp_bits"},
        {28'd0, resp_valid, resp_illegal, resp_misalign, resp_buserr}, 32'd0);
  endtask

  task automatic watch_no_resp(input string tag, input int cycles);
    bit seen;
    seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      dm_rvalid = 0;
      if (resp_valid) seen = 1;
    end
    chk({tag, " no_resp"}, {31'd0, seen}, 32'd0);
    chk({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    //          op    f3         addr          sd            rd            gd rvd lat req e_addr        e_wstrb  e_wdata       e_data        flags
    vecs[0]  = '{OP_S, SB_func3, 32'h0000_1003, 32'h0000_00AB, 32'h0,        0, 0,  2, 1, 32'h0000_1000, 4'b1000, 32'hABAB_ABAB, 32'h0,        3'b000};
    vecs[1]  = '{OP_L, LB_func3, 32'h0000_2001, 32'h0,        32'h1234_8056, 0, 3,  5, 1, 32'h0000_2000, 4'b0000, 32'h0,        32'hFFFF_FF80, 3'b000};
    vecs[2]  = '{OP_L, LBU_func3,32'h0000_2001, 32'h0,        32'h1234_8056, 0, 3,  5, 1, 32'h0000_2000, 4'b0000, 32'h0,        32'h0000_0080, 3'b000};
    vecs[3]  = '{OP_L, LW_func3, 32'h0000_2002, 32'h0,        32'h0,         0, 0,  1, 0, 32'h0,         4'b0000, 32'h0,        32'h0,         3'b010};
    vecs[4]  = '{OP_L, 3'b111,   32'h0000_2000, 32'h0,        32'h0,         0, 0,  1, 0, 32'h0,         4'b0000, 32'h0,        32'h0,         3'b100};
    vecs[5]  = '{OP_L, LW_func3, 32'h0000_3000, 32'h0,        32'h5555_5555, 0, -1, 18, 1, 32'h0000_3000, 4'b0000, 32'h0,       32'h0,         3'b001};
    vecs[6]  = '{OP_S, SW_func3, 32'h0000_4000, 32'hDEAD_BEEF, 32'h0,        5, 0,  7, 1, 32'h0000_4000, 4'b1111, 32'hDEAD_BEEF, 32'h0,        3'b000};
    vecs[7]  = '{OP_S, SH_func3, 32'h0000_4002, 32'h1234_ABCD, 32'h0,        0, 0,  2, 1, 32'h0000_4000, 4'b1100, 32'hABCD_ABCD, 32'h0,        3'b000};
    vecs[8]  = '{OP_L, LH_func3, 32'h0000_5002, 32'h0,        32'h8001_7FFF, 0, 0,  2, 1, 32'h0000_5000, 4'b0000, 32'h0,        32'hFFFF_8001, 3'b000};
    vecs[9]  = '{OP_L, LHU_func3,32'h0000_5002, 32'h0,        32'h8001_7FFF, 0, 0,  2, 1, 32'h0000_5000, 4'b0000, 32'h0,        32'h0000_8001, 3'b000};
    vecs[10] = '{OP_L, LW_func3, 32'h0000_6000, 32'h0,        32'hCAFE_F00D, 2, 1,  5, 1, 32'h0000_6000, 4'b0000, 32'h0,        32'hCAFE_F00D, 3'b000};
    vecs[11] = '{OP_S, SH_func3, 32'h0000_4001, 32'h0,        32'h0,         0, 0,  1, 0, 32'h0,         4'b0000, 32'h0,        32'h0,         3'b010};
    vecs[12] = '{OP_S, 3'b011,   32'h0000_4001, 32'h0,        32'h0,         0, 0,  1, 0, 32'h0,         4'b0000, 32'h0,        32'h0,         3'b100};
    vecs[13] = '{7'b0110011, 3'b000, 32'h0000_1000, 32'h0,    32'h0,         0, 0,  0, 0, 32'h0,         4'b0000, 32'h0,        32'h0,         3'b000};
    vecs[14] = '{OP_L, LB_func3, 32'h0000_7003, 32'h0,        32'h7F00_0000, 0, 16, 18, 1, 32'h0000_7000, 4'b0000, 32'h0,       32'h0000_007F, 3'b000};

    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    rst_n = 1;
    @(negedge clk);

    for (int i = 0; i < 15; i++) run_vec(i);

    // Timeout, then a stray rvalid in IDLE must be ignored.
    run_vec(5);
    @(negedge clk);
    dm_rvalid = 1; dm_rdata = 32'h1111_2222;
    watch_no_resp("late_rvalid", 4);

    // Async reset while a load sits in WAIT.
    @(negedge clk);
    in_valid = 1; opcode = OP_L; func3 = LW_func3; alu_out = 32'h0000_3000;
    @(posedge clk); #1;
    in_valid = 0; opcode = '0;
    @(negedge clk);
    chk("rst_wait req_before_gnt", {31'd0, dm_req}, 32'd1);
    dm_gnt = 1;
    @(negedge clk);
    dm_gnt = 0;
    @(negedge clk);
    chk("rst_wait busy", {30'd0, dm_req, in_ready}, 32'd0);
    rst_n = 0;
    #1;
    chk_idle_outputs("rst_wait");
    @(negedge clk);
    rst_n = 1;
    dm_rvalid = 1; dm_rdata = 32'hFFFF_FFFF;
    watch_no_resp("rst_wait", 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
